// File: rtl/usb1_host_reg_arb_if.sv
// Bundle of the arbiter's requester-side and core-side register bus signals.
// slave = arbiter view, master = the requesters and core that drive it.
interface usb1_host_reg_arb_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned AW     = 6,
  parameter int unsigned DW     = 32,
  parameter int unsigned TMO_W  = 8
);
  localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BEW = DW / 8;

  logic [NUM_CH-1:0]     ch_stb_i;
  logic [NUM_CH-1:0]     ch_we_i;
  logic [NUM_CH*AW-1:0]  ch_adr_i;
  logic [NUM_CH*DW-1:0]  ch_dat_i;
  logic [NUM_CH*BEW-1:0] ch_sel_i;
  logic [DW-1:0]         ch_dat_o;
  logic [NUM_CH-1:0]     ch_ack_o;
  logic [NUM_CH-1:0]     ch_err_o;
  logic                  reg_cs;
  logic                  reg_wr;
  logic [AW-1:0]         reg_addr;
  logic [DW-1:0]         reg_wdata;
  logic [BEW-1:0]        reg_be;
  logic [DW-1:0]         reg_rdata;
  logic                  reg_ack;
  logic [TMO_W-1:0]      tmo_limit_i;
  logic                  busy_o;
  logic [CHW-1:0]        grant_o;
  logic [7:0]            tmo_cnt_o;

  modport slave (
    input  ch_stb_i, ch_we_i, ch_adr_i, ch_dat_i, ch_sel_i, reg_rdata, reg_ack, tmo_limit_i,
    output ch_dat_o, ch_ack_o, ch_err_o, reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
           busy_o, grant_o, tmo_cnt_o
  );

  modport master (
    output ch_stb_i, ch_we_i, ch_adr_i, ch_dat_i, ch_sel_i, reg_rdata, reg_ack, tmo_limit_i,
    input  ch_dat_o, ch_ack_o, ch_err_o, reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
           busy_o, grant_o, tmo_cnt_o
  );
endinterface

// File: rtl/usb1_host_reg_arb.sv
// Round-robin arbiter sharing one usbh_core register port among NUM_CH requesters,
// with per-transaction timeout/error response and a saturating timeout counter.
module usb1_host_reg_arb #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned AW     = 6,
  parameter int unsigned DW     = 32,
  parameter int unsigned TMO_W  = 8
) (
  input  logic                usb_clk_i,
  input  logic                usb_rstn_i,
  usb1_host_reg_arb_if.slave  bus
);
  localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BEW = DW / 8;

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_e;

  state_e            state_q, state_d;
  logic [CHW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CHW-1:0]    grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              reg_cs_q, reg_cs_d;
  logic              reg_wr_q, reg_wr_d;
  logic [AW-1:0]     reg_addr_q, reg_addr_d;
  logic [DW-1:0]     reg_wdata_q, reg_wdata_d;
  logic [BEW-1:0]    reg_be_q, reg_be_d;
  logic [DW-1:0]     ch_dat_q, ch_dat_d;
  logic [NUM_CH-1:0] ch_ack_q, ch_ack_d;
  logic [NUM_CH-1:0] ch_err_q, ch_err_d;
  logic [TMO_W-1:0]  timer_q, timer_d;
  logic [7:0]        tmo_cnt_q, tmo_cnt_d;

  logic              hit;
  logic [CHW-1:0]    sel;
  logic              tmo_hit;

  // Round-robin pick: first requester at or above rr_ptr, else first below it.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int j = 0; j < int'(NUM_CH); j++) begin
      if (!hit && bus.ch_stb_i[j] && (CHW'(j) >= rr_ptr_q)) begin
        hit = 1'b1;
        sel = CHW'(j);
      end
    end
    for (int j = 0; j < int'(NUM_CH); j++) begin
      if (!hit && bus.ch_stb_i[j] && (CHW'(j) < rr_ptr_q)) begin
        hit = 1'b1;
        sel = CHW'(j);
      end
    end
  end

  assign tmo_hit = (bus.tmo_limit_i != '0) && (timer_q == bus.tmo_limit_i - TMO_W'(1));

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    reg_cs_d    = reg_cs_q;
    reg_wr_d    = reg_wr_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_be_d    = reg_be_q;
    ch_dat_d    = ch_dat_q;
    ch_ack_d    = '0;
    ch_err_d    = '0;
    timer_d     = timer_q;
    tmo_cnt_d   = tmo_cnt_q;

    case (state_q)
      IDLE: begin
        if (hit) begin
          for (int j = 0; j < int'(NUM_CH); j++) begin
            if (CHW'(j) == sel) begin
              reg_wr_d    = bus.ch_we_i[j];
              reg_addr_d  = bus.ch_adr_i[j*AW +: AW];
              reg_wdata_d = bus.ch_dat_i[j*DW +: DW];
              reg_be_d    = bus.ch_sel_i[j*BEW +: BEW];
            end
          end
          reg_cs_d = 1'b1;
          busy_d   = 1'b1;
          grant_d  = sel;
          timer_d  = '0;
          rr_ptr_d = (sel == CHW'(NUM_CH - 1)) ? '0 : sel + CHW'(1);
          state_d  = XFER;
        end
      end
      XFER: begin
        timer_d = timer_q + TMO_W'(1);
        // Ack takes priority over a timeout landing in the same cycle.
        if (bus.reg_ack) begin
          reg_cs_d = 1'b0;
          ch_dat_d = reg_wr_q ? '0 : bus.reg_rdata;
          for (int j = 0; j < int'(NUM_CH); j++) begin
            if (CHW'(j) == grant_q) ch_ack_d[j] = 1'b1;
          end
          state_d = RESP;
        end else if (tmo_hit) begin
          reg_cs_d = 1'b0;
          ch_dat_d = '0;
          for (int j = 0; j < int'(NUM_CH); j++) begin
            if (CHW'(j) == grant_q) ch_err_d[j] = 1'b1;
          end
          tmo_cnt_d = (tmo_cnt_q == 8'hFF) ? tmo_cnt_q : tmo_cnt_q + 8'd1;
          state_d   = RESP;
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge usb_clk_i) begin
    if (!usb_rstn_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      reg_cs_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_be_q    <= '0;
      ch_dat_q    <= '0;
      ch_ack_q    <= '0;
      ch_err_q    <= '0;
      timer_q     <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      reg_cs_q    <= reg_cs_d;
      reg_wr_q    <= reg_wr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_be_q    <= reg_be_d;
      ch_dat_q    <= ch_dat_d;
      ch_ack_q    <= ch_ack_d;
      ch_err_q    <= ch_err_d;
      timer_q     <= timer_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign bus.reg_cs    = reg_cs_q;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_be    = reg_be_q;
  assign bus.ch_dat_o  = ch_dat_q;
  assign bus.ch_ack_o  = ch_ack_q;
  assign bus.ch_err_o  = ch_err_q;
  assign bus.busy_o    = busy_q;
  assign bus.grant_o   = grant_q;
  assign bus.tmo_cnt_o = tmo_cnt_q;
endmodule

// File: doc/usb1_host_reg_arb.md
Name: usb1_host_reg_arb

Overview:
- Parametrised register-bus arbiter in the usb_clk_i domain.
- Shares one usbh_core register port (reg_cs/reg_wr/reg_addr/reg_wdata/reg_be/reg_rdata/reg_ack) among NUM_CH requesters, for example several async_wb slave ports or a local DMA/sequencer.
- Round-robin fairness, a per-transaction timeout with error response, and a saturating timeout counter for debug. The current single-requester wiring has none of these.

Parameters:
- NUM_CH, 2, number of requesting channels (1..8).
- AW, 6, register address width.
- DW, 32, data width; byte-enable width = DW/8.
- TMO_W, 8, width of timeout limit and counter.
- CHW, $clog2(NUM_CH) (minimum 1), grant index width (derived, not overridable).

Ports:
- usb_clk_i  in  1  clock, 48 MHz.
- usb_rstn_i  in  1  reset, synchronous, active-low.
- ch_stb_i  in  NUM_CH  per-channel request; held until that channel's ack or err.
- ch_we_i  in  NUM_CH  per-channel write.
- ch_adr_i  in  NUM_CH*AW  flattened addresses; channel k = bits [k*AW +: AW].
- ch_dat_i  in  NUM_CH*DW  flattened write data.
- ch_sel_i  in  NUM_CH*DW/8  flattened byte enables.
- ch_dat_o  out  DW  read data, shared; valid in the cycle ch_ack_o[k] is high.
- ch_ack_o  out  NUM_CH  one-cycle completion pulse.
- ch_err_o  out  NUM_CH  one-cycle timeout-error pulse.
- reg_cs  out  1  core select.
- reg_wr  out  1  core write.
- reg_addr  out  AW  core address.
- reg_wdata  out  DW  core write data.
- reg_be  out  DW/8  core byte enables.
- reg_rdata  in  DW  core read data, sampled when reg_ack is high.
- reg_ack  in  1  core acknowledge (single cycle).
- tmo_limit_i  in  TMO_W  timeout in cycles of reg_cs high; 0 disables the timeout.
- busy_o  out  1  transaction in flight.
- grant_o  out  CHW  index of the current or last granted channel.
- tmo_cnt_o  out  8  saturating count of timeouts.

Behaviour:
- Reset (usb_rstn_i low at a clock edge): state=IDLE, rr_ptr=0, and all outputs 0 (reg_cs, reg_wr, reg_addr, reg_wdata, reg_be, ch_dat_o, ch_ack_o, ch_err_o, busy_o, grant_o, tmo_cnt_o).
  - Reset mid-transaction aborts it silently: no ack or err is issued.
- States: IDLE, XFER, RESP.
- IDLE:
  - Select the first channel with ch_stb_i high, searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_CH-1, 0, ...).
  - On a hit, at the next edge: register the channel's we/adr/dat/sel onto the reg_* outputs, set reg_cs=1, busy_o=1, grant_o=k, clear the timer, set rr_ptr=(k+1) mod NUM_CH, and go to XFER.
  - Request seen in cycle N → reg_cs high in cycle N+1.
- XFER:
  - reg_cs and all reg_* outputs are held stable. The timer increments each cycle.
  - reg_ack=1: next edge sets reg_cs=0, ch_dat_o=reg_rdata (reads; writes drive 0), ch_ack_o[k]=1, and goes to RESP.
  - Timeout (tmo_limit_i!=0, timer==tmo_limit_i-1, reg_ack=0): next edge sets reg_cs=0, ch_dat_o=0, ch_err_o[k]=1, tmo_cnt_o+=1 (saturates at 255), and goes to RESP.
  - reg_ack and timeout in the same cycle: ack wins; no err, no count.
- RESP:
  - One cycle. ch_ack_o/ch_err_o high only in this cycle; busy_o stays 1.
  - Next edge: clear pulses, busy_o=0, go to IDLE.
  - Back-to-back throughput: one transaction per (core latency + 3) cycles. A channel re-asserting immediately is re-arbitrated against the others.
- ch_stb_i dropped by the master during XFER: the transaction still completes on the core side and the ack/err pulse is still issued; no retry.
- ch_stb_i inputs are sampled only in IDLE; changes on non-granted channels during XFER/RESP have no effect.
- ch_dat_o holds its last value until the next completion.
- NUM_CH=1: the arbiter degenerates to a registered pass-through; grant_o is always 0.
- reg_wr/reg_addr/reg_wdata/reg_be keep their last values when reg_cs=0.
- tmo_limit_i is sampled every cycle. Lowering it below the current timer value during XFER causes no timeout until the timer wraps; the timer is TMO_W bits and wraps.

Test Plan:
- Single read: ch0 stb, adr=0x04, core acks 2 cycles after reg_cs → reg_cs high cycles 1–3 (reg_ack in cycle 3); ch_ack_o[0] pulse cycle 4 with ch_dat_o=reg_rdata (e.g. 0x1234_5678); busy_o low cycle 5.
- Round-robin, NUM_CH=3: all three stb continuously, core acks in 1 cycle → grant order 0,1,2,0,1,2; each channel acked exactly once per three transactions.
- Timeout: tmo_limit_i=8, core never acks → reg_cs high exactly 8 cycles, ch_err_o[k] pulse, ch_dat_o=0, tmo_cnt_o=1; 256 further timeouts → tmo_cnt_o stays 255.
- Ack/timeout race: tmo_limit_i=4, reg_ack on the 4th reg_cs cycle → ch_ack_o only; tmo_cnt_o unchanged.
- Write with byte enables: ch1 we=1, adr=0x10, dat=0xA5A5_0F0F, sel=4'b0101 → reg_wr=1, reg_be=4'b0101, reg_wdata matches; ack pulse on ch1 only; ch_dat_o=0.
- Reset mid-XFER: usb_rstn_i low for 1 cycle while reg_cs=1 → all outputs 0 after the edge, no ack/err; the next request is granted from rr_ptr=0.
